// File: rtl/memory_access_stage_if.sv
// ============================================================================
// Module  : memory_access_stage_if
// Brief   : Data-memory req/gnt/rvalid bus between the MEM stage and memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface memory_access_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

`default_nettype wire

// File: rtl/memory_access_stage.sv
// ============================================================================
// Module  : memory_access_stage
// Brief   : MEM stage - data-memory load/store, pipeline stall, load
//           formatting and the MEM/WB register. Optional alignment checking
//           is enabled by defining MEM_MISALIGN_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_access_stage #(
    parameter int          XLEN             = 32,
    parameter logic [31:0] RESET_WRITE_DATA = 32'h0000_0000
) (
    input  wire logic              clk_i,
    input  wire logic              reset_ni,
    input  wire logic              em_reg_write_i,
    input  wire logic              em_mem_read_i,
    input  wire logic              em_mem_write_i,
    input  wire logic [1:0]        em_dmem_to_reg_i,
    input  wire logic [2:0]        em_funct3_i,
    input  wire logic [4:0]        em_write_reg_i,
    input  wire logic [XLEN-1:0]   em_alu_result_i,
    input  wire logic [XLEN-1:0]   em_read_data2_i,
    input  wire logic [XLEN-1:0]   em_pc_new_i,
    memory_access_stage_if.master  dmem,
    output logic                   mem_stall_o,
    output logic                   mw_reg_write_o,
    output logic [4:0]             mw_write_reg_o,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic                   misalign_o,
`endif
    output logic [XLEN-1:0]        mw_write_data_o
);

    localparam logic [0:0] S_IDLE        = 1'b0;
    localparam logic [0:0] S_WAIT_RVALID = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic            w_access;
    logic            w_load;
    logic            w_store;
    logic            w_is_byte;
    logic            w_is_half;
    logic            w_misalign;
    logic            w_issue;
    logic            w_idle;
    logic [1:0]      w_a;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_wb_data;

    // A simultaneous read+write request is a load; the write is dropped.
    assign w_access = em_mem_read_i | em_mem_write_i;
    assign w_load   = em_mem_read_i;
    assign w_store  = em_mem_write_i & ~em_mem_read_i;
    assign w_a      = em_alu_result_i[1:0];
    assign w_idle   = (r_state == S_IDLE);

    // Loads accept unsigned variants (1xx); stores treat every reserved code as word.
    always_comb begin
        w_is_byte = 1'b0;
        w_is_half = 1'b0;
        if (w_load) begin
            w_is_byte = (em_funct3_i[1:0] == 2'b00);
            w_is_half = (em_funct3_i[1:0] == 2'b01);
        end else begin
            w_is_byte = (em_funct3_i == 3'b000);
            w_is_half = (em_funct3_i == 3'b001);
        end
    end

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_misalign = w_access & ((w_is_half & w_a[0]) |
                                    (~w_is_byte & ~w_is_half & (w_a != 2'b00)));
    assign misalign_o = w_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    assign w_issue = w_access & ~w_misalign;

    // Bus request side
    assign dmem.req  = w_idle & w_issue;
    assign dmem.we   = w_idle & w_issue & w_store;
    assign dmem.addr = {em_alu_result_i[31:2], 2'b00};

    always_comb begin
        dmem.be    = 4'b0000;
        dmem.wdata = em_read_data2_i;
        if (w_is_byte) begin
            dmem.wdata = {4{em_read_data2_i[7:0]}};
        end else if (w_is_half) begin
            dmem.wdata = {2{em_read_data2_i[15:0]}};
        end
        if (w_idle & w_issue) begin
            if (w_is_byte) begin
                dmem.be = 4'b0001 << w_a;
            end else if (w_is_half) begin
                dmem.be = w_a[1] ? 4'b1100 : 4'b0011;
            end else begin
                dmem.be = 4'b1111;
            end
        end
    end

    assign mem_stall_o = (w_idle & w_issue & ~(w_store & dmem.gnt)) |
                         (~w_idle & ~dmem.rvalid);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:        if (w_issue & w_load & dmem.gnt) w_state_nxt = S_WAIT_RVALID;
            S_WAIT_RVALID: if (dmem.rvalid)                 w_state_nxt = S_IDLE;
            default:                                        w_state_nxt = S_IDLE;
        endcase
    end

    // Load lane extraction and sign/zero extension
    always_comb begin
        case (w_a)
            2'd0:    w_byte = dmem.rdata[7:0];
            2'd1:    w_byte = dmem.rdata[15:8];
            2'd2:    w_byte = dmem.rdata[23:16];
            default: w_byte = dmem.rdata[31:24];
        endcase
        w_half = w_a[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        case (em_funct3_i)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = dmem.rdata;
        endcase
    end

    always_comb begin
        case (em_dmem_to_reg_i)
            2'd1:    w_wb_data = w_load_data;
            2'd2:    w_wb_data = em_pc_new_i;
            default: w_wb_data = em_alu_result_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state         <= S_IDLE;
            mw_reg_write_o  <= 1'b0;
            mw_write_reg_o  <= 5'd0;
            mw_write_data_o <= RESET_WRITE_DATA;
        end else begin
            r_state <= w_state_nxt;
            if (mem_stall_o) begin
                mw_reg_write_o <= 1'b0;
            end else begin
                mw_reg_write_o  <= em_reg_write_i & ~w_misalign;
                mw_write_reg_o  <= em_write_reg_i;
                mw_write_data_o <= w_wb_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_access_stage.sv
// ============================================================================
// Module  : tb_memory_access_stage
// Brief   : Directed self-checking bench for memory_access_stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_access_stage;

    logic        clk;
    logic        reset_ni;
    logic        em_reg_write;
    logic        em_mem_read;
    logic        em_mem_write;
    logic [1:0]  em_dmem_to_reg;
    logic [2:0]  em_funct3;
    logic [4:0]  em_write_reg;
    logic [31:0] em_alu_result;
    logic [31:0] em_read_data2;
    logic [31:0] em_pc_new;
    logic        mem_stall;
    logic        mw_reg_write;
    logic [4:0]  mw_write_reg;
    logic [31:0] mw_write_data;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int n_cmp = 0;
    int n_err = 0;

    memory_access_stage_if bus ();

    memory_access_stage #(
        .XLEN             (32),
        .RESET_WRITE_DATA (32'h0000_0000)
    ) u_dut (
        .clk_i            (clk),
        .reset_ni         (reset_ni),
        .em_reg_write_i   (em_reg_write),
        .em_mem_read_i    (em_mem_read),
        .em_mem_write_i   (em_mem_write),
        .em_dmem_to_reg_i (em_dmem_to_reg),
        .em_funct3_i      (em_funct3),
        .em_write_reg_i   (em_write_reg),
        .em_alu_result_i  (em_alu_result),
        .em_read_data2_i  (em_read_data2),
        .em_pc_new_i      (em_pc_new),
        .dmem             (bus.master),
        .mem_stall_o      (mem_stall),
        .mw_reg_write_o   (mw_reg_write),
        .mw_write_reg_o   (mw_write_reg),
`ifdef MEM_MISALIGN_CHECK_EN
        .misalign_o       (misalign),
`endif
        .mw_write_data_o  (mw_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        em_reg_write   = 1'b0;
        em_mem_read    = 1'b0;
        em_mem_write   = 1'b0;
        em_dmem_to_reg = 2'd0;
        em_funct3      = 3'd0;
        em_write_reg   = 5'd0;
        em_alu_result  = 32'd0;
        em_read_data2  = 32'd0;
        em_pc_new      = 32'd0;
        bus.gnt        = 1'b0;
        bus.rvalid     = 1'b0;
        bus.rdata      = 32'd0;
    endtask

    // Load: gnt in the first cycle, rvalid two cycles after gnt.
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [4:0] rd,
                           input logic both, input logic [31:0] exp);
        @(negedge clk);
        em_mem_read    = 1'b1;
        em_mem_write   = both;
        em_reg_write   = 1'b1;
        em_dmem_to_reg = 2'd1;
        em_funct3      = f3;
        em_alu_result  = addr;
        em_read_data2  = 32'hFFFF_FFFF;
        em_write_reg   = rd;
        bus.gnt        = 1'b1;
        #1;
        chk({tag, "_req"},   {31'd0, bus.req},   32'd1);
        chk({tag, "_we"},    {31'd0, bus.we},    32'd0);
        chk({tag, "_stall"}, {31'd0, mem_stall}, 32'd1);
        chk({tag, "_addr"},  bus.addr,           {addr[31:2], 2'b00});
        @(posedge clk); #1;
        chk({tag, "_bubble"}, {31'd0, mw_reg_write}, 32'd0);
        @(negedge clk);
        bus.gnt = 1'b0;
        #1;
        chk({tag, "_wait_req"},   {31'd0, bus.req},   32'd0);
        chk({tag, "_wait_stall"}, {31'd0, mem_stall}, 32'd1);
        @(negedge clk);
        bus.rvalid = 1'b1;
        bus.rdata  = rdata;
        #1;
        chk({tag, "_rv_stall"}, {31'd0, mem_stall}, 32'd0);
        @(posedge clk); #1;
        chk({tag, "_wr"},   {31'd0, mw_reg_write}, 32'd1);
        chk({tag, "_rd"},   {27'd0, mw_write_reg}, {27'd0, rd});
        chk({tag, "_data"}, mw_write_data,         exp);
        @(negedge clk);
        idle_inputs();
    endtask

    // Store with immediate gnt.
    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
        @(negedge clk);
        em_mem_write  = 1'b1;
        em_funct3     = f3;
        em_alu_result = addr;
        em_read_data2 = data;
        bus.gnt       = 1'b1;
        #1;
        chk({tag, "_be"},    {28'd0, bus.be},    {28'd0, exp_be});
        chk({tag, "_wdata"}, bus.wdata,          exp_wdata);
        chk({tag, "_we"},    {31'd0, bus.we},    32'd1);
        chk({tag, "_stall"}, {31'd0, mem_stall}, 32'd0);
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        reset_ni = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   {31'd0, bus.req},      32'd0);
        chk("rst_we",    {31'd0, bus.we},       32'd0);
        chk("rst_be",    {28'd0, bus.be},       32'd0);
        chk("rst_stall", {31'd0, mem_stall},    32'd0);
        chk("rst_wr",    {31'd0, mw_reg_write}, 32'd0);
        chk("rst_rd",    {27'd0, mw_write_reg}, 32'd0);
        chk("rst_data",  mw_write_data,         32'd0);
        @(negedge clk);
        reset_ni = 1'b1;

        // ALU op
        @(negedge clk);
        em_reg_write  = 1'b1;
        em_alu_result = 32'h1234;
        em_write_reg  = 5'd5;
        #1;
        chk("alu_req",   {31'd0, bus.req},   32'd0);
        chk("alu_stall", {31'd0, mem_stall}, 32'd0);
        @(posedge clk); #1;
        chk("alu_wr",   {31'd0, mw_reg_write}, 32'd1);
        chk("alu_rd",   {27'd0, mw_write_reg}, 32'd5);
        chk("alu_data", mw_write_data,         32'h1234);

        // SB at 0x103 with gnt delayed 3 cycles
        @(negedge clk);
        idle_inputs();
        em_mem_write  = 1'b1;
        em_funct3     = 3'b000;
        em_alu_result = 32'h103;
        em_read_data2 = 32'hAB;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sb_wait_req",   {31'd0, bus.req},   32'd1);
            chk("sb_wait_stall", {31'd0, mem_stall}, 32'd1);
            @(posedge clk); #1;
            chk("sb_wait_bubble", {31'd0, mw_reg_write}, 32'd0);
            chk("sb_wait_hold",   mw_write_data,         32'h1234);
            @(negedge clk);
        end
        bus.gnt = 1'b1;
        #1;
        chk("sb_be",    {28'd0, bus.be},    32'h8);
        chk("sb_wdata", bus.wdata,          32'hABABABAB);
        chk("sb_addr",  bus.addr,           32'h100);
        chk("sb_we",    {31'd0, bus.we},    32'd1);
        chk("sb_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clk);
        idle_inputs();

        // Loads
        do_load("lb",     3'b000, 32'h201, 32'h0000_8000, 5'd7,  1'b0, 32'hFFFF_FF80);
        do_load("lbu",    3'b100, 32'h201, 32'h0000_8000, 5'd8,  1'b0, 32'h0000_0080);
        do_load("lb3",    3'b000, 32'h203, 32'h7F00_0000, 5'd9,  1'b0, 32'h0000_007F);
        do_load("lh",     3'b001, 32'h202, 32'h8001_0000, 5'd10, 1'b0, 32'hFFFF_8001);
        do_load("lhu",    3'b101, 32'h202, 32'h8001_0000, 5'd11, 1'b0, 32'h0000_8001);
        do_load("lw_rw",  3'b010, 32'h200, 32'h1234_5678, 5'd12, 1'b1, 32'h1234_5678);
        do_load("lw_rsv", 3'b111, 32'h208, 32'hCAFE_BABE, 5'd0,  1'b0, 32'hCAFE_BABE);

        // Writeback select: pc_new and the alternate ALU code
        @(negedge clk);
        em_reg_write   = 1'b1;
        em_dmem_to_reg = 2'd2;
        em_pc_new      = 32'h44;
        em_alu_result  = 32'h99;
        em_write_reg   = 5'd1;
        @(posedge clk); #1;
        chk("jal_data", mw_write_data,         32'h44);
        chk("jal_rd",   {27'd0, mw_write_reg}, 32'd1);
        @(negedge clk);
        em_dmem_to_reg = 2'd3;
        em_alu_result  = 32'h55;
        @(posedge clk); #1;
        chk("sel3_data", mw_write_data, 32'h55);
        @(negedge clk);
        idle_inputs();

        // Stores with immediate grant
        do_store("sh2", 3'b001, 32'h102, 32'h1111_BEEF, 4'b1100, 32'hBEEF_BEEF);
        do_store("sw",  3'b010, 32'h104, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        do_store("sb0", 3'b000, 32'h100, 32'h0000_0012, 4'b0001, 32'h1212_1212);

`ifdef MEM_MISALIGN_CHECK_EN
        @(negedge clk);
        em_mem_read    = 1'b1;
        em_reg_write   = 1'b1;
        em_dmem_to_reg = 2'd1;
        em_funct3      = 3'b010;
        em_alu_result  = 32'h2;
        em_write_reg   = 5'd3;
        bus.gnt        = 1'b1;
        #1;
        chk("mis_flag",  {31'd0, misalign},  32'd1);
        chk("mis_req",   {31'd0, bus.req},   32'd0);
        chk("mis_stall", {31'd0, mem_stall}, 32'd0);
        @(posedge clk); #1;
        chk("mis_bubble", {31'd0, mw_reg_write}, 32'd0);
        @(negedge clk);
        idle_inputs();
        do_load("lw4", 3'b010, 32'h4, 32'h0BAD_F00D, 5'd4, 1'b0, 32'h0BAD_F00D);
`else
        do_store("sh3", 3'b001, 32'h103, 32'h0000_A5C3, 4'b1100, 32'hA5C3_A5C3);
`endif

        // Reset while waiting for rvalid; a later stale rvalid must be dropped
        @(negedge clk);
        em_mem_read    = 1'b1;
        em_reg_write   = 1'b1;
        em_dmem_to_reg = 2'd1;
        em_funct3      = 3'b010;
        em_alu_result  = 32'h300;
        em_write_reg   = 5'd6;
        bus.gnt        = 1'b1;
        @(negedge clk);
        bus.gnt = 1'b0;
        #1;
        chk("rstw_stall", {31'd0, mem_stall}, 32'd1);
        #2;
        reset_ni = 1'b0;
        idle_inputs();
        #1;
        chk("rstw_req",   {31'd0, bus.req},      32'd0);
        chk("rstw_stall0",{31'd0, mem_stall},    32'd0);
        chk("rstw_wr",    {31'd0, mw_reg_write}, 32'd0);
        chk("rstw_data",  mw_write_data,         32'd0);
        @(negedge clk);
        reset_ni   = 1'b1;
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        chk("rstw_nocap", {31'd0, mw_reg_write}, 32'd0);
        @(negedge clk);
        bus.rvalid = 1'b0;
        #1;
        chk("rstw_idle_stall", {31'd0, mem_stall}, 32'd0);
        chk("rstw_idle_req",   {31'd0, bus.req},   32'd0);
        @(posedge clk); #1;
        chk("rstw_wr_after", {31'd0, mw_reg_write}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
